// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl - multiplexed-bus master for the RTC chip.
//
// Turns one register access (addr, wr_data, read/write) into a chip bus
// cycle: an address phase (a_d=0) and then a data phase (a_d=1). Each phase
// has setup, strobe and hold intervals of T_SU, T_PW and T_HD clocks. The
// address is always strobed with wr_n. The data phase uses wr_n for writes
// and rd_n for reads.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   wr_req, rd_req    request levels; a rising edge seen in IDLE starts a cycle
//   addr, wr_data     latched when a cycle starts
//   ad_in             bus value from the top-level tristate buffer
//   ad_out, ad_oe     bus drive value and output enable
//   cs_n, a_d         chip select (active low), address/data phase select
//   wr_n, rd_n        write and read strobes (active low)
//   busy, done        transaction in progress, one-cycle end pulse
//   rd_data           last read result
//
// State table:
//   IDLE | bus released, waiting for a request edge
//   A_SU | address driven, strobe high
//   A_PW | address driven, wr_n low
//   A_HD | address driven, strobe released
//   D_SU | data phase setup (write drives data, read releases bus)
//   D_PW | data phase strobe (wr_n or rd_n low)
//   D_HD | data phase hold, strobe released
//   DONE | bus released, done pulse

module rtc_bus_ctrl #(
    parameter int T_SU = 2,
    parameter int T_PW = 4,
    parameter int T_HD = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_req,
    input  logic       rd_req,
    input  logic [7:0] addr,
    input  logic [7:0] wr_data,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       a_d,
    output logic       wr_n,
    output logic       rd_n,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data
);

    typedef enum logic [2:0] {
        IDLE, A_SU, A_PW, A_HD, D_SU, D_PW, D_HD, DONE
    } state_t;

    localparam logic [3:0] SU_LAST = 4'(T_SU - 1);
    localparam logic [3:0] PW_LAST = 4'(T_PW - 1);
    localparam logic [3:0] HD_LAST = 4'(T_HD - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       wr_prev, rd_prev;
    logic       op_wr, op_wr_nxt;
    logic [7:0] addr_q, addr_nxt, wdata_q, wdata_nxt;
    logic [7:0] rd_data_nxt, ad_out_nxt;
    logic       ad_oe_nxt, cs_n_nxt, a_d_nxt, wr_n_nxt, rd_n_nxt;
    logic       busy_nxt, done_nxt;
    logic       wr_start, rd_start;

    assign wr_start = wr_req & ~wr_prev;
    assign rd_start = rd_req & ~rd_prev;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 4'd1;
        op_wr_nxt   = op_wr;
        addr_nxt    = addr_q;
        wdata_nxt   = wdata_q;
        rd_data_nxt = rd_data;

        case (state)
            IDLE: begin
                // Write wins when both edges land in the same cycle.
                if (wr_start || rd_start) begin
                    state_nxt = A_SU;
                    op_wr_nxt = wr_start;
                    addr_nxt  = addr;
                    wdata_nxt = wr_data;
                end
            end
            A_SU: if (cnt == SU_LAST) state_nxt = A_PW;
            A_PW: if (cnt == PW_LAST) state_nxt = A_HD;
            A_HD: if (cnt == HD_LAST) state_nxt = D_SU;
            D_SU: if (cnt == SU_LAST) state_nxt = D_PW;
            D_PW: begin
                if (cnt == PW_LAST) begin
                    state_nxt = D_HD;
                    if (!op_wr) rd_data_nxt = ad_in;
                end
            end
            D_HD: if (cnt == HD_LAST) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (state_nxt != state || state == IDLE) cnt_nxt = 4'd0;

        // Output decode from the next state so the outputs are registered
        // and move on the same edge as the state.
        ad_out_nxt = 8'h00;
        ad_oe_nxt  = 1'b0;
        cs_n_nxt   = 1'b1;
        a_d_nxt    = 1'b1;
        wr_n_nxt   = 1'b1;
        rd_n_nxt   = 1'b1;
        busy_nxt   = (state_nxt != IDLE);
        done_nxt   = 1'b0;

        case (state_nxt)
            A_SU, A_PW, A_HD: begin
                cs_n_nxt   = 1'b0;
                a_d_nxt    = 1'b0;
                ad_oe_nxt  = 1'b1;
                ad_out_nxt = addr_nxt;
                wr_n_nxt   = (state_nxt != A_PW);
            end
            D_SU, D_PW, D_HD: begin
                cs_n_nxt = 1'b0;
                if (op_wr_nxt) begin
                    ad_oe_nxt  = 1'b1;
                    ad_out_nxt = wdata_nxt;
                    wr_n_nxt   = (state_nxt != D_PW);
                end else begin
                    rd_n_nxt   = (state_nxt != D_PW);
                end
            end
            DONE: done_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            wr_prev <= 1'b1;
            rd_prev <= 1'b1;
            op_wr   <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            rd_data <= 8'h00;
            ad_out  <= 8'h00;
            ad_oe   <= 1'b0;
            cs_n    <= 1'b1;
            a_d     <= 1'b1;
            wr_n    <= 1'b1;
            rd_n    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            wr_prev <= wr_req;
            rd_prev <= rd_req;
            op_wr   <= op_wr_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
            rd_data <= rd_data_nxt;
            ad_out  <= ad_out_nxt;
            ad_oe   <= ad_oe_nxt;
            cs_n    <= cs_n_nxt;
            a_d     <= a_d_nxt;
            wr_n    <= wr_n_nxt;
            rd_n    <= rd_n_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Bench for rtc_bus_ctrl: a default-timing instance (index 0) and a
// T_SU=T_PW=T_HD=1 instance (index 1) share the same stimulus. A model
// tracks each transaction by its cycle number and derives the bus values.

module tb_rtc_bus_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic wr_req = 1'b0, rd_req = 1'b0;
    logic [7:0] addr = 8'h00, wr_data = 8'h00, ad_in = 8'h00;

    logic [1:0][7:0] ad_out_v, rd_data_v;
    logic [1:0] ad_oe_v, cs_n_v, a_d_v, wr_n_v, rd_n_v, busy_v, done_v;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    always #5 clk = ~clk;

    rtc_bus_ctrl #(.T_SU(2), .T_PW(4), .T_HD(2)) dut_d (
        .clk(clk), .reset(reset), .wr_req(wr_req), .rd_req(rd_req),
        .addr(addr), .wr_data(wr_data), .ad_in(ad_in),
        .ad_out(ad_out_v[0]), .ad_oe(ad_oe_v[0]), .cs_n(cs_n_v[0]),
        .a_d(a_d_v[0]), .wr_n(wr_n_v[0]), .rd_n(rd_n_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .rd_data(rd_data_v[0]));

    rtc_bus_ctrl #(.T_SU(1), .T_PW(1), .T_HD(1)) dut_f (
        .clk(clk), .reset(reset), .wr_req(wr_req), .rd_req(rd_req),
        .addr(addr), .wr_data(wr_data), .ad_in(ad_in),
        .ad_out(ad_out_v[1]), .ad_oe(ad_oe_v[1]), .cs_n(cs_n_v[1]),
        .a_d(a_d_v[1]), .wr_n(wr_n_v[1]), .rd_n(rd_n_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .rd_data(rd_data_v[1]));

    // ---------------- model ----------------
    int su[2] = '{2, 1};
    int pw[2] = '{4, 1};
    int hd[2] = '{2, 1};
    int mk[2];               // cycle number inside the transaction, 0 = idle
    bit mwr[2];
    logic [7:0] maddr[2], mwd[2], mrd[2];
    bit mwp[2], mrp[2];

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                mk[i] = 0; mwp[i] = 1'b1; mrp[i] = 1'b1; mrd[i] = 8'h00;
            end else begin
                int h, len;
                h   = su[i] + pw[i] + hd[i];
                len = 2 * h + 1;
                if (mk[i] != 0) begin
                    if (mk[i] == h + su[i] + pw[i] && !mwr[i]) mrd[i] = ad_in;
                    mk[i] = (mk[i] == len) ? 0 : mk[i] + 1;
                end else if (wr_req && !mwp[i]) begin
                    mk[i] = 1; mwr[i] = 1'b1; maddr[i] = addr; mwd[i] = wr_data;
                end else if (rd_req && !mrp[i]) begin
                    mk[i] = 1; mwr[i] = 1'b0; maddr[i] = addr; mwd[i] = wr_data;
                end
                mwp[i] = wr_req;
                mrp[i] = rd_req;
            end
        end
    end

    // ctl = {cs_n, a_d, wr_n, rd_n, ad_oe, busy, done}
    task automatic model_out(input int i, output logic [6:0] ctl,
                             output logic [7:0] out, output bit chk_out);
        int h, len, j;
        bit data, strobe;
        h   = su[i] + pw[i] + hd[i];
        len = 2 * h + 1;
        chk_out = 1'b1;
        out = 8'h00;
        if (mk[i] == 0)        ctl = 7'b1111000;
        else if (mk[i] == len) ctl = 7'b1111011;
        else begin
            data   = (mk[i] > h);
            j      = data ? mk[i] - h : mk[i];
            strobe = (j > su[i]) && (j <= su[i] + pw[i]);
            if (!data) begin
                ctl = {1'b0, 1'b0, ~strobe, 1'b1, 1'b1, 1'b1, 1'b0};
                out = maddr[i];
            end else if (mwr[i]) begin
                ctl = {1'b0, 1'b1, ~strobe, 1'b1, 1'b1, 1'b1, 1'b0};
                out = mwd[i];
            end else begin
                ctl = {1'b0, 1'b1, 1'b1, ~strobe, 1'b0, 1'b1, 1'b0};
                chk_out = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [6:0] ectl, actl;
                logic [7:0] eout;
                bit chk_out;
                model_out(i, ectl, eout, chk_out);
                actl = {cs_n_v[i], a_d_v[i], wr_n_v[i], rd_n_v[i],
                        ad_oe_v[i], busy_v[i], done_v[i]};
                n_tests++;
                if (actl !== ectl || (chk_out && ad_out_v[i] !== eout) ||
                    rd_data_v[i] !== mrd[i]) begin
                    n_fail++;
                    $display("FAIL model_cmp inst%0d t=%0t k=%0d: got ctl=%b ad_out=%h rd_data=%h, want ctl=%b ad_out=%h rd_data=%h",
                             i, $time, mk[i], actl, ad_out_v[i], rd_data_v[i],
                             ectl, eout, mrd[i]);
                end
            end
        end
    end

    // ---------------- directed checks ----------------
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int cnt_d, cnt_f, cnt_b;
        cyc(3);
        #2 reset = 1'b0;
        cmp_en = 1'b1;
        cyc(2);

        // write with default timing
        addr = 8'h41; wr_data = 8'h05; wr_req = 1'b1;
        cyc(1);
        chk("t1_c1_cs_n", cs_n_v[0], 0); chk("t1_c1_a_d", a_d_v[0], 0);
        chk("t1_c1_ad_out", ad_out_v[0], 8'h41);
        addr = 8'hff; wr_data = 8'haa;
        cyc(2);
        chk("t1_c3_wr_n", wr_n_v[0], 0);
        cyc(3);
        chk("t1_c6_wr_n", wr_n_v[0], 0);
        cyc(1);
        chk("t1_c7_wr_n", wr_n_v[0], 1); chk("t6_c7_done", done_v[1], 1);
        chk("t6_model_k", 8'(mk[1]), 8'd7);
        cyc(2);
        chk("t1_c9_ad_out", ad_out_v[0], 8'h05); chk("t1_c9_a_d", a_d_v[0], 1);
        cyc(2);
        chk("t1_c11_wr_n", wr_n_v[0], 0);
        cyc(6);
        chk("t1_c17_done", done_v[0], 1); chk("t1_c17_busy", busy_v[0], 1);
        chk("t1_model_k", 8'(mk[0]), 8'd17);
        cyc(1);
        chk("t1_c18_busy", busy_v[0], 0); chk("t1_c18_done", done_v[0], 0);

        // read
        wr_req = 1'b0; cyc(2);
        addr = 8'h42; ad_in = 8'h37; rd_req = 1'b1;
        cyc(3);
        chk("t2_c3_wr_n", wr_n_v[0], 0); chk("t2_c3_rd_n", rd_n_v[0], 1);
        cyc(4);
        chk("t6_rd_data", rd_data_v[1], 8'h37);
        cyc(2);
        chk("t2_c9_ad_oe", ad_oe_v[0], 0);
        cyc(2);
        chk("t2_c11_rd_n", rd_n_v[0], 0); chk("t2_c11_wr_n", wr_n_v[0], 1);
        cyc(6);
        chk("t2_c17_done", done_v[0], 1); chk("t2_rd_data", rd_data_v[0], 8'h37);
        chk("t2_model_rd", mrd[0], 8'h37);
        rd_req = 1'b0; cyc(2);
        ad_in = 8'h00; wr_req = 1'b1;
        cyc(20);
        chk("t2_rd_after_wr", rd_data_v[0], 8'h37);

        // held request
        wr_req = 1'b0; cyc(2);
        wr_req = 1'b1; cnt_d = 0; cnt_f = 0;
        repeat (600) begin
            cyc(1);
            if (done_v[0]) cnt_d++;
            if (done_v[1]) cnt_f++;
        end
        chk("t3_done_cnt_d", 8'(cnt_d), 8'd1); chk("t3_done_cnt_f", 8'(cnt_f), 8'd1);
        wr_req = 1'b0;

        // simultaneous edges, then a read edge while busy
        cyc(2);
        addr = 8'h10; wr_data = 8'h5a; wr_req = 1'b1; rd_req = 1'b1; cnt_d = 0;
        for (int c = 1; c <= 30; c++) begin
            cyc(1);
            if (c == 2) rd_req = 1'b0;
            if (c == 4) rd_req = 1'b1;
            if (c == 9) chk("t4_c9_ad_oe", ad_oe_v[0], 1);
            if (done_v[0]) cnt_d++;
        end
        chk("t4_done_cnt", 8'(cnt_d), 8'd1); chk("t4_rd_data", rd_data_v[0], 8'h37);
        wr_req = 1'b0; rd_req = 1'b0;

        // reset during D_PW, request held across release
        cyc(2);
        wr_req = 1'b1;
        cyc(12);
        #2 reset = 1'b1;
        #1;
        chk("t5_cs_n", cs_n_v[0], 1); chk("t5_wr_n", wr_n_v[0], 1);
        chk("t5_ad_oe", ad_oe_v[0], 0); chk("t5_busy", busy_v[0], 0);
        chk("t5_done", done_v[0], 0);
        cyc(1);
        #2 reset = 1'b0;
        cnt_d = 0; cnt_b = 0;
        repeat (30) begin
            cyc(1);
            if (done_v[0]) cnt_d++;
            if (busy_v[0]) cnt_b++;
        end
        chk("t5_no_done", 8'(cnt_d), 8'd0); chk("t5_no_busy", 8'(cnt_b), 8'd0);
        chk("t5_rd_data", rd_data_v[0], 8'h00);
        wr_req = 1'b0;

        // random traffic
        cyc(2);
        repeat (3000) begin
            cyc(1);
            if ($urandom_range(0, 5) == 0) wr_req = ~wr_req;
            if ($urandom_range(0, 5) == 0) rd_req = ~rd_req;
            addr    = 8'($urandom);
            wr_data = 8'($urandom);
            ad_in   = 8'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                #1 reset = 1'b1;
                #2 reset = 1'b0;
            end
        end

        cyc(1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
